// File: rtl/avalon_pio_test_master.sv
// Avalon-MM test master: writes a rolling 16-bit pattern to one register, reads it
// back, and keeps saturating pass/error counts plus a sticky transfer-timeout flag.
module avalon_pio_test_master #(
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned TARGET_ADDR = 0,
  parameter logic [15:0] SEED        = 16'h0000,
  parameter int unsigned PERIOD      = 1000,
  parameter int unsigned TIMEOUT     = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic [15:0]       pattern,
  output logic [15:0]       pass_count,
  output logic [15:0]       err_count,
  output logic              timeout
);

  localparam logic [31:0] WAIT_LOAD  = 32'(PERIOD - 1);
  localparam logic [31:0] STALL_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_CHK  = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  state_t      r_state;
  logic        r_write;
  logic        r_read;
  logic        r_stop;
  logic        r_timeout;
  logic [15:0] r_pattern;
  logic [15:0] r_pass;
  logic [15:0] r_err;
  logic [15:0] r_rdata;
  logic [31:0] r_wait;
  logic [31:0] r_stall;
  logic        w_unused_rdata;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Test sequencer: state, strobes, pattern, counters and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_stop    <= 1'b0;
      r_timeout <= 1'b0;
      r_pattern <= 16'h0000;
      r_pass    <= 16'h0000;
      r_err     <= 16'h0000;
      r_rdata   <= 16'h0000;
      r_wait    <= 32'd0;
      r_stall   <= 32'd0;
    end else begin
      // Later assignments in the case below take priority when IDLE is entered
      if (stop && (r_state != ST_IDLE)) begin
        r_stop <= 1'b1;
      end else begin
        r_stop <= r_stop;
      end
      case (r_state)
        ST_IDLE: begin
          if (start && !stop) begin
            r_pattern <= SEED;
            r_pass    <= 16'h0000;
            r_err     <= 16'h0000;
            r_timeout <= 1'b0;
            r_stop    <= 1'b0;
            r_stall   <= 32'd0;
            r_write   <= 1'b1;
            r_state   <= ST_WR;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (!avm_waitrequest) begin
            r_write <= 1'b0;
            r_read  <= 1'b1;
            r_stall <= 32'd0;
            r_state <= ST_RD;
          end else if (r_stall == STALL_LAST) begin
            r_write   <= 1'b0;
            r_timeout <= 1'b1;
            r_stop    <= 1'b0;
            r_stall   <= 32'd0;
            r_state   <= ST_IDLE;
          end else begin
            r_stall <= r_stall + 32'd1;
          end
        end
        ST_RD: begin
          if (!avm_waitrequest) begin
            r_read  <= 1'b0;
            r_rdata <= avm_readdata[15:0];
            r_stall <= 32'd0;
            r_state <= ST_CHK;
          end else if (r_stall == STALL_LAST) begin
            r_read    <= 1'b0;
            r_timeout <= 1'b1;
            r_stop    <= 1'b0;
            r_stall   <= 32'd0;
            r_state   <= ST_IDLE;
          end else begin
            r_stall <= r_stall + 32'd1;
          end
        end
        ST_CHK: begin
          if (r_rdata == r_pattern) begin
            r_pass <= sat_inc(r_pass);
          end else begin
            r_err <= sat_inc(r_err);
          end
          // A stop arriving in this very cycle still ends the run here
          if (r_stop || stop) begin
            r_stop  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_wait  <= WAIT_LOAD;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_wait == 32'd0) begin
            r_pattern <= r_pattern + 16'd1;
            r_stall   <= 32'd0;
            r_write   <= 1'b1;
            r_state   <= ST_WR;
          end else begin
            r_wait <= r_wait - 32'd1;
          end
        end
        default: begin
          r_write <= 1'b0;
          r_read  <= 1'b0;
          r_stop  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_unused_rdata = ^avm_readdata[31:16];

  assign avm_address   = ADDR_W'(TARGET_ADDR);
  assign avm_writedata = {16'h0000, r_pattern};
  assign avm_write     = r_write;
  assign avm_read      = r_read;
  assign busy          = (r_state != ST_IDLE);
  assign pattern       = r_pattern;
  assign pass_count    = r_pass;
  assign err_count     = r_err;
  assign timeout       = r_timeout;

endmodule

// File: tb/tb_avalon_pio_test_master.sv
// Bench for avalon_pio_test_master: configurable Avalon slave model, a write
// scoreboard fed by the stimulus, and directed checks of counters and status.
module tb_avalon_pio_test_master;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [1:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;
  logic        busy, timeout;
  logic [15:0] pattern, pass_count, err_count;

  int checks = 0;
  int errors = 0;

  // slave model controls
  int          wait_cycles = 0;
  bit          stuck = 1'b0;
  bit          xor_mode = 1'b0;
  int          sl_cnt = 0;
  logic [15:0] mem = 16'h0000;

  logic [15:0] exp_wr[$];
  int wr_run = 0, rd_run = 0, last_wr_len = 0, last_rd_len = 0;
  logic        prev_write = 1'b0;
  logic [31:0] prev_wd = 32'd0;

  avalon_pio_test_master #(
    .ADDR_W(2), .TARGET_ADDR(1), .SEED(16'hFFFE), .PERIOD(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .busy(busy), .pattern(pattern),
    .pass_count(pass_count), .err_count(err_count), .timeout(timeout)
  );

  always #5 clk = ~clk;

  assign avm_waitrequest = stuck || ((avm_write || avm_read) && (sl_cnt < wait_cycles));
  assign avm_readdata    = {16'hA5A5, xor_mode ? (mem ^ 16'h0001) : mem};

  // Slave: stall counter per transfer and the single backing register
  always @(posedge clk) begin
    if (!(avm_write || avm_read)) sl_cnt <= 0;
    else if (avm_waitrequest)     sl_cnt <= sl_cnt + 1;
    else                          sl_cnt <= 0;
    if (avm_write && !avm_waitrequest) mem <= avm_writedata[15:0];
  end

  // Monitor: scoreboard on accepted writes, protocol and stability checks
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (avm_write || avm_read) begin
        checks++;
        if (avm_write && avm_read) begin
          errors++;
          $display("FAIL strobe_overlap: write=%0b read=%0b, required not both", avm_write, avm_read);
        end
      end
      if (avm_write && prev_write) begin
        checks++;
        if (avm_writedata !== prev_wd) begin
          errors++;
          $display("FAIL wd_stable: got %h, required %h", avm_writedata, prev_wd);
        end
      end
      if (avm_write && !avm_waitrequest) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got data %h, required no write", avm_writedata);
        end else begin
          e = exp_wr.pop_front();
          if (avm_writedata !== {16'h0000, e} || avm_address !== 2'd1) begin
            errors++;
            $display("FAIL write_data: got %h@%0d, required %h@1", avm_writedata, avm_address, e);
          end
        end
      end
      if (avm_write) wr_run++;
      else if (wr_run != 0) begin last_wr_len = wr_run; wr_run = 0; end
      if (avm_read) rd_run++;
      else if (rd_run != 0) begin last_rd_len = rd_run; rd_run = 0; end
      prev_write = avm_write;
      prev_wd    = avm_writedata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_pattern(input string name, input logic [15:0] val, input int budget);
    int n = 0;
    while (pattern !== val && n < budget) begin tick(); n++; end
    check(name, {16'd0, pattern}, {16'd0, val});
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; stop = 1'b0;
    tick(); tick();
    start = 1'b0; reset = 1'b0;
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_strobes", {30'd0, avm_write, avm_read}, 32'd0);
    check("reset_pattern", {16'd0, pattern}, 32'd0);
    check("reset_counts", {pass_count, err_count}, 32'd0);
    check("reset_timeout", {31'd0, timeout}, 32'd0);

    // start together with stop in IDLE is ignored
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("start_stop_ignored", {31'd0, busy}, 32'd0);

    // echo slave, three iterations through the 16-bit wrap
    exp_wr.push_back(16'hFFFE); exp_wr.push_back(16'hFFFF); exp_wr.push_back(16'h0000);
    pulse_start();
    check("start_latency_write", {31'd0, avm_write}, 32'd1);
    wait_pattern("reach_third", 16'h0000, 40);
    pulse_stop();
    tick(); tick();
    check("idle_after_third_chk", {31'd0, busy}, 32'd0);
    check("run1_pass", {16'd0, pass_count}, 32'd3);
    check("run1_err", {16'd0, err_count}, 32'd0);

    // two stall cycles per transfer
    wait_cycles = 2;
    exp_wr.push_back(16'hFFFE);
    pulse_start();
    pulse_stop();
    wait_idle("run2_idle", 30);
    tick();
    check("stall_write_len", last_wr_len, 32'd3);
    check("stall_read_len", last_rd_len, 32'd3);
    check("run2_pass", {16'd0, pass_count}, 32'd1);
    check("run2_err", {16'd0, err_count}, 32'd0);

    // corrupting slave, four iterations; stray stop in IDLE and start while busy
    wait_cycles = 0; xor_mode = 1'b1;
    pulse_stop();
    exp_wr.push_back(16'hFFFE); exp_wr.push_back(16'hFFFF);
    exp_wr.push_back(16'h0000); exp_wr.push_back(16'h0001);
    pulse_start();
    tick();
    pulse_start();
    wait_pattern("reach_fourth", 16'h0001, 40);
    pulse_stop();
    wait_idle("run3_idle", 20);
    check("run3_err", {16'd0, err_count}, 32'd4);
    check("run3_pass", {16'd0, pass_count}, 32'd0);

    // waitrequest stuck high: timeout after eight stalled cycles
    xor_mode = 1'b0; stuck = 1'b1;
    pulse_start();
    wait_idle("run4_idle", 30);
    tick();
    stuck = 1'b0;
    check("timeout_write_len", last_wr_len, 32'd8);
    check("timeout_flag", {31'd0, timeout}, 32'd1);
    check("timeout_counts", {pass_count, err_count}, 32'd0);
    exp_wr.push_back(16'hFFFE);
    pulse_start();
    check("timeout_cleared", {31'd0, timeout}, 32'd0);
    pulse_stop();
    wait_idle("run5_idle", 20);
    check("run5_pass", {16'd0, pass_count}, 32'd1);

    // reset during a stalled read
    wait_cycles = 3;
    exp_wr.push_back(16'hFFFE);
    pulse_start();
    begin
      int n = 0;
      while (!avm_read && n < 20) begin tick(); n++; end
    end
    check("read_reached", {31'd0, avm_read}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_read_drop", {30'd0, avm_write, avm_read}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_counts", {pass_count, err_count}, 32'd0);
    check("rst_pattern", {16'd0, pattern}, 32'd0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (avm_write || avm_read) seen = 1'b1;
      end
      check("no_strobe_after_reset", {31'd0, seen}, 32'd0);
    end
    check("scoreboard_drained", exp_wr.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
